// File: rtl/data_ram_ctrl_pkg.sv
// Shared types and constants for the data-memory controller.
// FSM state encodings and the register-bus word type.
package data_ram_ctrl_pkg;

    localparam int unsigned RegBusWidth = 32;

    typedef logic [RegBusWidth-1:0] reg_bus_t;

    localparam reg_bus_t ZeroWord = '0;

    typedef enum logic [1:0] {
        DrcIdle = 2'd0,
        DrcBusy = 2'd1,
        DrcAck  = 2'd2
    } drc_state_e;

endpackage

// File: rtl/data_ram_array.sv
// DEPTH-word RAM built from four byte-wide lanes.
// Synchronous per-lane write; read data follows idx combinationally.
module data_ram_array #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    sel,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [3:0][7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we && sel[i]) begin
                mem[idx][i] <= wdata[i*8 +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/data_ram_ctrl.sv
// Multi-cycle data-memory controller: IDLE -> BUSY (WAIT_CYCLES) -> ACK.
// Optional MEM_RANGE_CHECK_EN adds ram_err and suppresses out-of-range accesses.
module data_ram_ctrl
    import data_ram_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_ce,
    input  logic        ram_we,
    input  logic [31:0] ram_addr,
    input  logic [3:0]  ram_sel,
    input  logic [31:0] ram_data_i,
    output logic [31:0] ram_data_o,
    output logic        data_ready
`ifdef MEM_RANGE_CHECK_EN
    ,
    output logic        ram_err
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [3:0] CntInit = 4'(WAIT_CYCLES - 1);

    drc_state_e    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [3:0]    sel_q, sel_d;
    logic [AW-1:0] idx_q, idx_d;
    reg_bus_t      wdata_q, wdata_d;
    logic          err_q, err_d;
    reg_bus_t      data_q, data_d;

    logic          ready_int;
    logic          arr_we;
    reg_bus_t      arr_rdata;
    logic          range_err;

`ifdef MEM_RANGE_CHECK_EN
    assign range_err = (ram_addr >> (AW + 2)) != 32'h0;
    assign ram_err   = (state_q == DrcAck) && err_q;
    logic unused_addr;
    assign unused_addr = ^ram_addr[1:0];
`else
    assign range_err = 1'b0;
    // Upper bits deliberately dropped: out-of-range addresses alias modulo DEPTH.
    logic unused_addr;
    assign unused_addr = ^{ram_addr[31:AW+2], ram_addr[1:0]};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DrcIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            idx_q   <= '0;
            wdata_q <= ZeroWord;
            err_q   <= 1'b0;
            data_q  <= ZeroWord;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        sel_d     = sel_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        data_d    = data_q;
        ready_int = 1'b0;
        arr_we    = 1'b0;

        unique case (state_q)
            DrcIdle: begin
                ready_int = !ram_ce;
                if (ram_ce) begin
                    we_d    = ram_we;
                    sel_d   = ram_sel;
                    idx_d   = ram_addr[AW+1:2];
                    wdata_d = ram_data_i;
                    err_d   = range_err;
                    cnt_d   = CntInit;
                    state_d = DrcBusy;
                end
            end
            DrcBusy: begin
                if (cnt_q == 4'd0) begin
                    arr_we = we_q && !err_q;
                    if (!we_q) begin
                        data_d = err_q ? ZeroWord : arr_rdata;
                    end
                    state_d = DrcAck;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DrcAck: begin
                ready_int = 1'b1;
                state_d   = DrcIdle;
            end
            default: state_d = DrcIdle;
        endcase
    end

    // Hold data_ready low for the whole time reset is asserted, not just after it.
    assign data_ready = rst && ready_int;
    assign ram_data_o = data_q;

    data_ram_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .sel   (sel_q),
        .idx   (idx_q),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Directed bench for data_ram_ctrl with a load-data scoreboard.
// Honours MEM_RANGE_CHECK_EN when defined.
module tb_data_ram_ctrl;

    localparam int unsigned Wait = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_ce;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [3:0]  ram_sel;
    logic [31:0] ram_data_i;
    logic [31:0] ram_data_o;
    logic        data_ready;
`ifdef MEM_RANGE_CHECK_EN
    logic        ram_err;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [int];
    logic [31:0] exp_q [$];
    logic [31:0] last_load;

    data_ram_ctrl #(
        .DEPTH       (1024),
        .WAIT_CYCLES (Wait)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ram_ce     (ram_ce),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_sel    (ram_sel),
        .ram_data_i (ram_data_i),
        .ram_data_o (ram_data_o),
        .data_ready (data_ready)
`ifdef MEM_RANGE_CHECK_EN
        ,
        .ram_err    (ram_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit out_of_range(input logic [31:0] addr);
`ifdef MEM_RANGE_CHECK_EN
        return (addr >> 12) != 32'h0;
`else
        return 1'b0;
`endif
    endfunction

    // Apply stimulus-side effects on the reference model and scoreboard.
    task automatic model_issue(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                               input logic [31:0] data);
        int k;
        logic [31:0] w;
        k = int'(addr[11:2]);
        if (we) begin
            if (!out_of_range(addr)) begin
                w = model.exists(k) ? model[k] : 32'h0;
                for (int i = 0; i < 4; i++) begin
                    if (sel[i]) w[i*8 +: 8] = data[i*8 +: 8];
                end
                if (sel != 4'b0000 || model.exists(k)) model[k] = w;
            end
        end else begin
            exp_q.push_back(out_of_range(addr) ? 32'h0 : model[k]);
        end
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end while (!data_ready && n < 50);
    endtask

    task automatic complete(input logic we, input logic [31:0] addr, input string tag);
        logic [31:0] e;
        if (!we) begin
            e = exp_q.pop_front();
            check({tag, "_load_data"}, ram_data_o, e);
            last_load = e;
        end else begin
            check({tag, "_store_keeps_data_o"}, ram_data_o, last_load);
        end
`ifdef MEM_RANGE_CHECK_EN
        check({tag, "_ram_err_ack"}, {31'b0, ram_err}, {31'b0, out_of_range(addr)});
`endif
    endtask

    // Full handshake starting from an IDLE negedge; returns at the next IDLE negedge.
    task automatic access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                          input logic [31:0] data, input string tag);
        int n;
        ram_ce     = 1'b1;
        ram_we     = we;
        ram_addr   = addr;
        ram_sel    = sel;
        ram_data_i = data;
        model_issue(we, addr, sel, data);
        wait_ack(n);
        check({tag, "_latency"}, n, Wait + 1);
        complete(we, addr, tag);
        ram_ce = 1'b0;
        @(negedge clk);
        check({tag, "_idle_ready"}, {31'b0, data_ready}, 32'd1);
`ifdef MEM_RANGE_CHECK_EN
        check({tag, "_ram_err_idle"}, {31'b0, ram_err}, 32'd0);
`endif
    endtask

    initial begin
        int n;
        rst        = 1'b0;
        ram_ce     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_sel    = '0;
        ram_data_i = '0;
        last_load  = '0;

        @(negedge clk);
        check("reset_ready", {31'b0, data_ready}, 32'd0);
        check("reset_data_o", ram_data_o, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_ready", {31'b0, data_ready}, 32'd1);

        // Reset aborts an in-flight store.
        access(1'b1, 32'h10, 4'b1111, 32'h0102_0304, "pre_store");
        access(1'b0, 32'h10, 4'b1111, 32'h0, "pre_load");
        ram_ce = 1'b1; ram_we = 1'b1; ram_addr = 32'h10; ram_sel = 4'b1111;
        ram_data_i = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_ready", {31'b0, data_ready}, 32'd0);
        check("abort_data_o", ram_data_o, 32'h0);
        last_load = 32'h0;
        ram_ce = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_busy", {31'b0, data_ready}, 32'd1);
        end
        access(1'b0, 32'h10, 4'b0000, 32'h0, "abort_reload");

        // Full-word store/load, byte lanes, empty-sel store, ignored low address bits.
        access(1'b1, 32'h20, 4'b1111, 32'h1122_3344, "store20");
        access(1'b0, 32'h20, 4'b1111, 32'h0, "load20");
        access(1'b1, 32'h20, 4'b0101, 32'hAABB_CCDD, "lane_store");
        access(1'b0, 32'h20, 4'b0000, 32'h0, "lane_load");
        access(1'b1, 32'h20, 4'b0000, 32'hFFFF_FFFF, "nosel_store");
        access(1'b0, 32'h23, 4'b1010, 32'h0, "nosel_load");

        // Back-to-back: load 0x4 with ce held into store 0x8.
        access(1'b1, 32'h4, 4'b1111, 32'hCAFE_0004, "seed4");
        access(1'b1, 32'h8, 4'b1111, 32'h0000_0008, "seed8");
        ram_ce = 1'b1; ram_we = 1'b0; ram_addr = 32'h4; ram_sel = 4'b1111;
        model_issue(1'b0, 32'h4, 4'b1111, 32'h0);
        wait_ack(n);
        check("b2b_first_latency", n, Wait + 1);
        complete(1'b0, 32'h4, "b2b_first");
        ram_we = 1'b1; ram_addr = 32'h8; ram_data_i = 32'h0BAD_F00D;
        model_issue(1'b1, 32'h8, 4'b1111, 32'h0BAD_F00D);
        wait_ack(n);
        check("b2b_spacing", n, Wait + 2);
        complete(1'b1, 32'h8, "b2b_second");
        ram_ce = 1'b0;
        @(negedge clk);
        check("b2b_idle_ready", {31'b0, data_ready}, 32'd1);
        access(1'b0, 32'h8, 4'b1111, 32'h0, "b2b_verify");

        // Bus changes during BUSY are ignored.
        ram_ce = 1'b1; ram_we = 1'b0; ram_addr = 32'h4; ram_sel = 4'b1111;
        model_issue(1'b0, 32'h4, 4'b1111, 32'h0);
        @(posedge clk);
        @(negedge clk);
        ram_we = 1'b1; ram_addr = 32'h8; ram_data_i = 32'h7777_7777;
        wait_ack(n);
        check("busy_change_latency", n + 1, Wait + 1);
        complete(1'b0, 32'h4, "busy_change");
        ram_ce = 1'b0;
        @(negedge clk);
        access(1'b0, 32'h8, 4'b1111, 32'h0, "busy_change_no_write");

        // Out-of-range store: suppressed with range check, aliases to word 0 without.
        access(1'b1, 32'h0, 4'b1111, 32'h1234_5678, "seed0");
        access(1'b1, 32'h1000, 4'b1111, 32'h0000_0055, "oor_store");
        access(1'b0, 32'h0, 4'b1111, 32'h0, "oor_load0");
        access(1'b0, 32'h1000, 4'b1111, 32'h0, "oor_load1000");

        if (exp_q.size() != 0) begin
            check("scoreboard_empty", exp_q.size(), 32'd0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
